adma_desc_sched: RTL and testbench

ADMA_DESC_SCHED -- requirements
Module: adma_desc_sched

---
 rtl/adma_desc_sched.sv | 195 +++++++++++++++++++
 tb/tb_adma_desc_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adma_desc_sched.sv
// Descriptor scheduler: round-robin arbitration over per-channel descriptor queues,
// issuing one descriptor at a time to the DMA engine and reporting per-channel completion.
module adma_desc_sched #(
    parameter int DMA_WR_CHN_NUM = 4,
    parameter int SRC_ADDR_W     = 32,
    parameter int DST_ADDR_W     = 32,
    parameter int DMA_LENGTH_W   = 16,
    localparam int CHN_W         = (DMA_WR_CHN_NUM > 1) ? $clog2(DMA_WR_CHN_NUM) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   sched_en_i,
    input  logic [DMA_WR_CHN_NUM-1:0]              chn_en_i,
    input  logic [DMA_WR_CHN_NUM*SRC_ADDR_W-1:0]   src_addr_i,
    input  logic [DMA_WR_CHN_NUM*DST_ADDR_W-1:0]   dst_addr_i,
    input  logic [DMA_WR_CHN_NUM*DMA_LENGTH_W-1:0] xfer_xlen_i,
    input  logic [DMA_WR_CHN_NUM*DMA_LENGTH_W-1:0] xfer_ylen_i,
    input  logic [DMA_WR_CHN_NUM*DMA_LENGTH_W-1:0] src_stride_i,
    input  logic [DMA_WR_CHN_NUM*DMA_LENGTH_W-1:0] dst_stride_i,
    input  logic [DMA_WR_CHN_NUM-1:0]              desc_avail_i,
    output logic [DMA_WR_CHN_NUM-1:0]              desc_pop_o,
    output logic [SRC_ADDR_W-1:0]                  xfer_src_addr_o,
    output logic [DST_ADDR_W-1:0]                  xfer_dst_addr_o,
    output logic [DMA_LENGTH_W-1:0]                xfer_xlen_o,
    output logic [DMA_LENGTH_W-1:0]                xfer_ylen_o,
    output logic [DMA_LENGTH_W-1:0]                xfer_src_stride_o,
    output logic [DMA_LENGTH_W-1:0]                xfer_dst_stride_o,
    output logic [CHN_W-1:0]                       xfer_chn_o,
    output logic                                   xfer_vld_o,
    input  logic                                   xfer_rdy_i,
    input  logic                                   xfer_done_i,
    output logic [DMA_WR_CHN_NUM-1:0]              chn_done_o,
    output logic [DMA_WR_CHN_NUM-1:0]              chn_err_o,
    output logic                                   sched_busy_o
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    logic [1:0]                r_state;
    logic [CHN_W-1:0]          r_rrPtr;
    logic [SRC_ADDR_W-1:0]     r_srcAddr;
    logic [DST_ADDR_W-1:0]     r_dstAddr;
    logic [DMA_LENGTH_W-1:0]   r_xlen;
    logic [DMA_LENGTH_W-1:0]   r_ylen;
    logic [DMA_LENGTH_W-1:0]   r_srcStride;
    logic [DMA_LENGTH_W-1:0]   r_dstStride;
    logic [CHN_W-1:0]          r_chn;
    logic                      r_vld;
    logic [DMA_WR_CHN_NUM-1:0] r_chnDone;
    logic [DMA_WR_CHN_NUM-1:0] r_chnErr;

    logic [DMA_WR_CHN_NUM-1:0] w_req;
    logic                      w_hiFound;
    logic                      w_loFound;
    logic [CHN_W-1:0]          w_hiIdx;
    logic [CHN_W-1:0]          w_loIdx;
    logic                      w_grantVld;
    logic [CHN_W-1:0]          w_grantIdx;
    logic [DMA_WR_CHN_NUM-1:0] w_popMask;
    logic [SRC_ADDR_W-1:0]     w_srcAddr;
    logic [DST_ADDR_W-1:0]     w_dstAddr;
    logic [DMA_LENGTH_W-1:0]   w_xlen;
    logic [DMA_LENGTH_W-1:0]   w_ylen;
    logic [DMA_LENGTH_W-1:0]   w_srcStride;
    logic [DMA_LENGTH_W-1:0]   w_dstStride;
    logic                      w_zeroLen;

    assign w_req = desc_avail_i & chn_en_i;

    // Descending scan leaves the lowest requester above the pointer in w_hiIdx and the
    // lowest one at or below it in w_loIdx; the upper group has priority, giving the wrap.
    always_comb begin
        w_hiFound = 1'b0;
        w_loFound = 1'b0;
        w_hiIdx   = '0;
        w_loIdx   = '0;
        for (int c = DMA_WR_CHN_NUM - 1; c >= 0; c--) begin
            if (w_req[c]) begin
                if (c > int'(r_rrPtr)) begin
                    w_hiFound = 1'b1;
                    w_hiIdx   = CHN_W'(c);
                end else begin
                    w_loFound = 1'b1;
                    w_loIdx   = CHN_W'(c);
                end
            end
        end
    end

    assign w_grantVld = (r_state == S_IDLE) && sched_en_i && (w_hiFound || w_loFound);
    assign w_grantIdx = w_hiFound ? w_hiIdx : w_loIdx;

    always_comb begin
        w_popMask = '0;
        if (w_grantVld) begin
            w_popMask[w_grantIdx] = 1'b1;
        end
    end

    assign w_srcAddr   = src_addr_i[w_grantIdx*SRC_ADDR_W +: SRC_ADDR_W];
    assign w_dstAddr   = dst_addr_i[w_grantIdx*DST_ADDR_W +: DST_ADDR_W];
    assign w_xlen      = xfer_xlen_i[w_grantIdx*DMA_LENGTH_W +: DMA_LENGTH_W];
    assign w_ylen      = xfer_ylen_i[w_grantIdx*DMA_LENGTH_W +: DMA_LENGTH_W];
    assign w_srcStride = src_stride_i[w_grantIdx*DMA_LENGTH_W +: DMA_LENGTH_W];
    assign w_dstStride = dst_stride_i[w_grantIdx*DMA_LENGTH_W +: DMA_LENGTH_W];
    assign w_zeroLen   = (w_xlen == '0) || (w_ylen == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_vld   <= 1'b0;
            r_rrPtr <= CHN_W'(DMA_WR_CHN_NUM - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grantVld) begin
                        r_rrPtr <= w_grantIdx;
                        if (!w_zeroLen) begin
                            r_vld   <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (xfer_rdy_i) begin
                        r_vld   <= 1'b0;
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (xfer_done_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_vld   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Descriptor fields are captured on every grant, including skipped zero-length ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_srcAddr   <= '0;
            r_dstAddr   <= '0;
            r_xlen      <= '0;
            r_ylen      <= '0;
            r_srcStride <= '0;
            r_dstStride <= '0;
            r_chn       <= '0;
        end else if (w_grantVld) begin
            r_srcAddr   <= w_srcAddr;
            r_dstAddr   <= w_dstAddr;
            r_xlen      <= w_xlen;
            r_ylen      <= w_ylen;
            r_srcStride <= w_srcStride;
            r_dstStride <= w_dstStride;
            r_chn       <= w_grantIdx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chnDone <= '0;
            r_chnErr  <= '0;
        end else begin
            r_chnDone <= '0;
            r_chnErr  <= '0;
            if (w_grantVld && w_zeroLen) begin
                r_chnDone[w_grantIdx] <= 1'b1;
                r_chnErr[w_grantIdx]  <= 1'b1;
            end else if ((r_state == S_WAIT_DONE) && xfer_done_i) begin
                r_chnDone[r_chn] <= 1'b1;
            end
        end
    end

    assign desc_pop_o        = w_popMask;
    assign xfer_src_addr_o   = r_srcAddr;
    assign xfer_dst_addr_o   = r_dstAddr;
    assign xfer_xlen_o       = r_xlen;
    assign xfer_ylen_o       = r_ylen;
    assign xfer_src_stride_o = r_srcStride;
    assign xfer_dst_stride_o = r_dstStride;
    assign xfer_chn_o        = r_chn;
    assign xfer_vld_o        = r_vld;
    assign chn_done_o        = r_chnDone;
    assign chn_err_o         = r_chnErr;
    assign sched_busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_adma_desc_sched.sv
// Bench for adma_desc_sched: a transaction-level scheduler model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_adma_desc_sched;

    localparam int N   = 4;
    localparam int SAW = 32;
    localparam int DAW = 32;
    localparam int LW  = 16;
    localparam int CW  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sched_en;
    logic [N-1:0]     chn_en;
    logic [N-1:0]     avail;
    logic [N*SAW-1:0] srcAddr;
    logic [N*DAW-1:0] dstAddr;
    logic [N*LW-1:0]  xlen;
    logic [N*LW-1:0]  ylen;
    logic [N*LW-1:0]  srcStride;
    logic [N*LW-1:0]  dstStride;
    logic             rdy;
    logic             done;

    logic [N-1:0]     desc_pop_o;
    logic [SAW-1:0]   xfer_src_addr_o;
    logic [DAW-1:0]   xfer_dst_addr_o;
    logic [LW-1:0]    xfer_xlen_o;
    logic [LW-1:0]    xfer_ylen_o;
    logic [LW-1:0]    xfer_src_stride_o;
    logic [LW-1:0]    xfer_dst_stride_o;
    logic [CW-1:0]    xfer_chn_o;
    logic             xfer_vld_o;
    logic [N-1:0]     chn_done_o;
    logic [N-1:0]     chn_err_o;
    logic             sched_busy_o;

    int errCount   = 0;
    int checkCount = 0;
    int popCount   = 0;
    int issueQ[$];

    // Transaction-level model: one in-flight descriptor record plus pending pulse masks.
    bit           mBusy;
    bit           mIssued;
    int           mChn;
    int           mLast;
    int           mG;
    logic [SAW-1:0] mSrc;
    logic [DAW-1:0] mDst;
    logic [LW-1:0]  mXl;
    logic [LW-1:0]  mYl;
    logic [LW-1:0]  mSs;
    logic [LW-1:0]  mDs;
    logic [N-1:0] mDone;
    logic [N-1:0] mErr;
    logic [N-1:0] mExpPop;
    logic [N-1:0] mNextDone;
    logic [N-1:0] mNextErr;

    adma_desc_sched #(
        .DMA_WR_CHN_NUM(N),
        .SRC_ADDR_W(SAW),
        .DST_ADDR_W(DAW),
        .DMA_LENGTH_W(LW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sched_en_i(sched_en),
        .chn_en_i(chn_en),
        .src_addr_i(srcAddr),
        .dst_addr_i(dstAddr),
        .xfer_xlen_i(xlen),
        .xfer_ylen_i(ylen),
        .src_stride_i(srcStride),
        .dst_stride_i(dstStride),
        .desc_avail_i(avail),
        .desc_pop_o(desc_pop_o),
        .xfer_src_addr_o(xfer_src_addr_o),
        .xfer_dst_addr_o(xfer_dst_addr_o),
        .xfer_xlen_o(xfer_xlen_o),
        .xfer_ylen_o(xfer_ylen_o),
        .xfer_src_stride_o(xfer_src_stride_o),
        .xfer_dst_stride_o(xfer_dst_stride_o),
        .xfer_chn_o(xfer_chn_o),
        .xfer_vld_o(xfer_vld_o),
        .xfer_rdy_i(rdy),
        .xfer_done_i(done),
        .chn_done_o(chn_done_o),
        .chn_err_o(chn_err_o),
        .sched_busy_o(sched_busy_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sEn, input logic [N-1:0] en, input logic [N-1:0] av,
                                 input logic r, input logic d);
        sched_en = sEn;
        chn_en   = en;
        avail    = av;
        rdy      = r;
        done     = d;
    endtask

    task automatic setDesc(input int c, input logic [SAW-1:0] s, input logic [DAW-1:0] dd,
                           input logic [LW-1:0] xl, input logic [LW-1:0] yl,
                           input logic [LW-1:0] ss, input logic [LW-1:0] ds);
        srcAddr[c*SAW +: SAW]  = s;
        dstAddr[c*DAW +: DAW]  = dd;
        xlen[c*LW +: LW]       = xl;
        ylen[c*LW +: LW]       = yl;
        srcStride[c*LW +: LW]  = ss;
        dstStride[c*LW +: LW]  = ds;
    endtask

    task automatic waitVld(input int maxCycles);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < maxCycles && !seen; n++) begin
            tick();
            if (xfer_vld_o === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checkCount++;
            errCount++;
            $display("[TB] FAIL wait_vld: got no xfer_vld_o, expected it within %0d cycles", maxCycles);
        end
    endtask

    // Engine side: accept (rdy already high), then complete 3 cycles later.
    task automatic engineComplete();
        tick();
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    // Round-robin rule: first requesting channel after the last grant, wrapping.
    function automatic int pickGrant();
        int c;
        if (!sched_en) return -1;
        for (int k = 1; k <= N; k++) begin
            c = (mLast + k) % N;
            if (avail[c] && chn_en[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mBusy   = 1'b0;
            mIssued = 1'b0;
            mLast   = N - 1;
            mDone   = '0;
            mErr    = '0;
            checkOutput("rst_vld", xfer_vld_o, 0);
            checkOutput("rst_pop", desc_pop_o, 0);
            checkOutput("rst_busy", sched_busy_o, 0);
            checkOutput("rst_done", chn_done_o, 0);
            checkOutput("rst_err", chn_err_o, 0);
        end else begin
            mG      = mBusy ? -1 : pickGrant();
            mExpPop = '0;
            if (mG >= 0) mExpPop[mG] = 1'b1;
            checkOutput("pop", desc_pop_o, mExpPop);
            checkOutput("busy", sched_busy_o, mBusy);
            checkOutput("vld", xfer_vld_o, mBusy && !mIssued);
            checkOutput("chn_done", chn_done_o, mDone);
            checkOutput("chn_err", chn_err_o, mErr);
            if (mBusy) checkOutput("chn", xfer_chn_o, mChn);
            if (mBusy && !mIssued) begin
                checkOutput("src", xfer_src_addr_o, mSrc);
                checkOutput("dst", xfer_dst_addr_o, mDst);
                checkOutput("xlen", xfer_xlen_o, mXl);
                checkOutput("ylen", xfer_ylen_o, mYl);
                checkOutput("sstride", xfer_src_stride_o, mSs);
                checkOutput("dstride", xfer_dst_stride_o, mDs);
            end
            if (xfer_vld_o && rdy) issueQ.push_back(int'(xfer_chn_o));
            popCount += $countones(desc_pop_o);

            mNextDone = '0;
            mNextErr  = '0;
            if (mG >= 0) begin
                mLast = mG;
                if (xlen[mG*LW +: LW] == 0 || ylen[mG*LW +: LW] == 0) begin
                    mNextDone[mG] = 1'b1;
                    mNextErr[mG]  = 1'b1;
                end else begin
                    mBusy   = 1'b1;
                    mIssued = 1'b0;
                    mChn    = mG;
                    mSrc    = srcAddr[mG*SAW +: SAW];
                    mDst    = dstAddr[mG*DAW +: DAW];
                    mXl     = xlen[mG*LW +: LW];
                    mYl     = ylen[mG*LW +: LW];
                    mSs     = srcStride[mG*LW +: LW];
                    mDs     = dstStride[mG*LW +: LW];
                end
            end else if (mBusy && !mIssued) begin
                if (rdy) mIssued = 1'b1;
            end else if (mBusy && done) begin
                mNextDone[mChn] = 1'b1;
                mBusy           = 1'b0;
            end
            mDone = mNextDone;
            mErr  = mNextErr;
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expOrder[5];
        int p0;
        int val;
        expOrder = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        for (int c = 0; c < N; c++) begin
            setDesc(c, 32'h1000_0000 + 32'(c) * 32'h100, 32'h2000_0000 + 32'(c) * 32'h100,
                    16'h0020 + 16'(c), 16'h0002, 16'h0040, 16'h0080);
        end
        tick();
        tick();
        checkOutput("reset_vld", xfer_vld_o, 0);
        checkOutput("reset_busy", sched_busy_o, 0);
        checkOutput("reset_chn", xfer_chn_o, 0);
        checkOutput("reset_src", xfer_src_addr_o, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] round-robin over all four channels");
        issueQ.delete();
        p0 = popCount;
        applyStimulus(1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            waitVld(20);
            if (i == 4) avail = '0;
            engineComplete();
        end
        tick();
        tick();
        checkOutput("order_len", issueQ.size(), 5);
        for (int i = 0; i < 5; i++) begin
            val = (i < issueQ.size()) ? issueQ[i] : -1;
            checkOutput($sformatf("order%0d", i), val, expOrder[i]);
        end
        checkOutput("pop_total", popCount - p0, 5);

        $display("[TB] single channel 2 descriptor with held-off engine");
        setDesc(2, 32'h0000_1000, 32'h0000_3000, 16'h0010, 16'h0004, 16'h0100, 16'h0200);
        applyStimulus(1'b1, 4'hF, 4'b0100, 1'b0, 1'b0);
        #1;
        checkOutput("t2_pop", desc_pop_o, 4'b0100);
        tick();
        avail = 4'b1011;
        checkOutput("t2_vld", xfer_vld_o, 1);
        checkOutput("t2_src", xfer_src_addr_o, 32'h1000);
        checkOutput("t2_xlen", xfer_xlen_o, 16'h0010);
        checkOutput("t2_ylen", xfer_ylen_o, 16'h0004);
        checkOutput("t2_chn", xfer_chn_o, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("t2_hold_vld%0d", i), xfer_vld_o, 1);
            checkOutput($sformatf("t2_hold_src%0d", i), xfer_src_addr_o, 32'h1000);
            checkOutput($sformatf("t2_hold_pop%0d", i), desc_pop_o, 0);
        end
        avail = '0;
        rdy   = 1'b1;
        tick();
        rdy = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checkOutput("t2_done", chn_done_o, 4'b0100);
        checkOutput("t2_err", chn_err_o, 0);

        $display("[TB] zero-length descriptor on channel 1");
        setDesc(1, 32'h0000_5000, 32'h0000_6000, 16'h0000, 16'h0008, 16'h0010, 16'h0010);
        applyStimulus(1'b1, 4'hF, 4'b0010, 1'b0, 1'b0);
        #1;
        checkOutput("t3_pop", desc_pop_o, 4'b0010);
        tick();
        avail = '0;
        checkOutput("t3_err", chn_err_o, 4'b0010);
        checkOutput("t3_done", chn_done_o, 4'b0010);
        checkOutput("t3_vld", xfer_vld_o, 0);
        checkOutput("t3_busy", sched_busy_o, 0);
        tick();
        tick();
        tick();
        checkOutput("t3_vld_late", xfer_vld_o, 0);

        $display("[TB] scheduler disabled during WAIT_DONE");
        applyStimulus(1'b1, 4'hF, 4'b0001, 1'b1, 1'b0);
        waitVld(20);
        checkOutput("t4_chn", xfer_chn_o, 0);
        tick();
        applyStimulus(1'b0, 4'hF, 4'b1000, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("t4_busy", sched_busy_o, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        checkOutput("t4_done", chn_done_o, 4'b0001);
        tick();
        tick();
        tick();
        checkOutput("t4_nopop", desc_pop_o, 0);
        checkOutput("t4_idle", sched_busy_o, 0);
        sched_en = 1'b1;
        rdy      = 1'b1;
        #1;
        checkOutput("t4_pop3", desc_pop_o, 4'b1000);
        waitVld(5);
        avail = '0;
        engineComplete();
        rdy = 1'b0;
        tick();

        $display("[TB] reset during WAIT_DONE");
        applyStimulus(1'b1, 4'hF, 4'b0100, 1'b1, 1'b0);
        waitVld(20);
        avail = '0;
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("t5_vld", xfer_vld_o, 0);
        checkOutput("t5_busy", sched_busy_o, 0);
        checkOutput("t5_chn", xfer_chn_o, 0);
        checkOutput("t5_src", xfer_src_addr_o, 0);
        checkOutput("t5_dst", xfer_dst_addr_o, 0);
        checkOutput("t5_xlen", xfer_xlen_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checkOutput("t5_nodone", chn_done_o, 0);
        checkOutput("t5_idle", sched_busy_o, 0);
        avail = 4'hF;
        #1;
        checkOutput("t5_pop0", desc_pop_o, 4'b0001);
        waitVld(5);
        avail = '0;
        engineComplete();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
